// File: rtl/sublime_voice_scheduler_pkg.sv
// Shared constants for the voice bus: frame sequencer state encoding and
// velocity width, used by the scheduler, the mixer and the note-control logic.
package sublime_voice_scheduler_pkg;

    localparam int VEL_W = 8;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } sched_state_e;

endpackage

// File: rtl/sublime_voice_scheduler_table.sv
// Per-voice velocity register file: one synchronous write port, one
// combinational read port. Writes addressed beyond the last voice are dropped
// so a non-power-of-2 voice count cannot alias into a real entry.
module sublime_voice_table
    import sublime_voice_scheduler_pkg::*;
#(
    parameter int NUM_VOICES = 8
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          we_i,
    input  logic [$clog2(NUM_VOICES)-1:0] waddr_i,
    input  logic [VEL_W-1:0]              wdata_i,
    input  logic [$clog2(NUM_VOICES)-1:0] raddr_i,
    output logic [VEL_W-1:0]              rdata_o
);

    localparam int IDX_W = $clog2(NUM_VOICES);
    localparam logic [IDX_W:0] NUM_VOICES_L = (IDX_W + 1)'(NUM_VOICES);

    logic [VEL_W-1:0] mem_q [NUM_VOICES];
    logic             wr_ok_s;

    assign wr_ok_s = we_i && ({1'b0, waddr_i} < NUM_VOICES_L);
    assign rdata_o = mem_q[raddr_i];

    // Clear all entries on reset, otherwise store an in-range write.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_ok_s) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

endmodule

// File: rtl/sublime_voice_scheduler.sv
// Frame sequencer for the voice-mixer side of the voice bus. Each accepted
// sample tick walks voices NUM_VOICES-1 down to 0, one slot of SLOT_CYCLES
// cycles per voice, strobing the voice index and its velocity at slot start.
// Voice 0 closes the frame; a tick in that last cycle chains the next frame.
module sublime_voice_scheduler
    import sublime_voice_scheduler_pkg::*;
#(
    parameter int NUM_VOICES  = 8,
    parameter int SLOT_CYCLES = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          sample_tick_i,
    input  logic                          note_we_i,
    input  logic [$clog2(NUM_VOICES)-1:0] note_voice_i,
    input  logic [VEL_W-1:0]              note_velocity_i,
    output logic [$clog2(NUM_VOICES)-1:0] active_voice_o,
    output logic                          active_voice_changed_o,
    output logic [VEL_W-1:0]              active_voice_velocity_o,
    output logic                          busy_o,
    output logic                          overrun_o
);

    localparam int IDX_W  = $clog2(NUM_VOICES);
    localparam int SLOT_W = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;

    localparam logic [IDX_W-1:0]  LAST_VOICE = IDX_W'(NUM_VOICES - 1);
    localparam logic [IDX_W-1:0]  ONE_VOICE  = IDX_W'(1);
    localparam logic [SLOT_W-1:0] LAST_SLOT  = SLOT_W'(SLOT_CYCLES - 1);
    localparam logic [SLOT_W-1:0] ONE_SLOT   = SLOT_W'(1);

    sched_state_e      state_q;
    logic [SLOT_W-1:0] slot_q;
    logic [IDX_W-1:0]  voice_q;
    logic              changed_q;
    logic [VEL_W-1:0]  vel_q;
    logic              busy_q;
    logic              overrun_q;

    logic [IDX_W-1:0]  voice_d;
    logic [VEL_W-1:0]  tab_rdata_s;
    logic              last_slot_s;
    logic              frame_end_s;

    assign last_slot_s = (slot_q == LAST_SLOT);
    assign frame_end_s = (state_q == ST_RUN) && last_slot_s && (voice_q == '0);

    // The voice a strobe would announce next: the following lower voice while
    // a frame still has voices left, otherwise the top voice of a new frame.
    // The table is read through this address so the velocity is sampled at
    // the same edge the strobe is registered.
    assign voice_d = ((state_q == ST_RUN) && (voice_q != '0)) ? (voice_q - ONE_VOICE)
                                                             : LAST_VOICE;

    sublime_voice_table #(
        .NUM_VOICES (NUM_VOICES)
    ) u_table (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .we_i    (note_we_i),
        .waddr_i (note_voice_i),
        .wdata_i (note_velocity_i),
        .raddr_i (voice_d),
        .rdata_o (tab_rdata_s)
    );

    // Frame FSM with slot/voice counters and all registered outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            slot_q    <= '0;
            voice_q   <= LAST_VOICE;
            changed_q <= 1'b0;
            vel_q     <= '0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            changed_q <= 1'b0;
            overrun_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (sample_tick_i) begin
                        state_q   <= ST_RUN;
                        busy_q    <= 1'b1;
                        slot_q    <= '0;
                        voice_q   <= voice_d;
                        changed_q <= 1'b1;
                        vel_q     <= tab_rdata_s;
                    end else begin
                        busy_q    <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (!last_slot_s) begin
                        slot_q <= slot_q + ONE_SLOT;
                    end else if ((voice_q != '0) || sample_tick_i) begin
                        // Next voice of this frame, or the chained next frame.
                        slot_q    <= '0;
                        voice_q   <= voice_d;
                        changed_q <= 1'b1;
                        vel_q     <= tab_rdata_s;
                    end else begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        slot_q  <= '0;
                    end
                    if (sample_tick_i && !frame_end_s) begin
                        overrun_q <= 1'b1;
                    end else begin
                        overrun_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    slot_q  <= '0;
                end
            endcase
        end
    end

    assign active_voice_o          = voice_q;
    assign active_voice_changed_o  = changed_q;
    assign active_voice_velocity_o = vel_q;
    assign busy_o                  = busy_q;
    assign overrun_o               = overrun_q;

endmodule

// File: tb/tb_sublime_voice_scheduler.sv
// Scoreboard bench for sublime_voice_scheduler: an 8-voice/4-cycle instance
// and a 5-voice/1-cycle instance. Expected strobes are queued when ticks are
// driven and popped as the DUT strobes; cycle t inputs are driven at the
// negedge of cycle t and outputs of cycle t are sampled at that same negedge.
module tb_sublime_voice_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick, we;
    logic [2:0] nv;
    logic [7:0] nvel;
    logic [2:0] av;
    logic       ch, busy, ovr;
    logic [7:0] vel;

    logic       tick2, we2;
    logic [2:0] nv2;
    logic [7:0] nvel2;
    logic [2:0] av2;
    logic       ch2, busy2, ovr2;
    logic [7:0] vel2;

    typedef struct {
        int cyc;
        int voice;
        int vel;
    } exp_t;

    exp_t q[$];
    exp_t q2[$];
    int   m_tab[8];
    int   m2[5];
    int   busy_from, busy_until, ovr_at;
    int   passed = 0;
    int   total  = 0;

    always #5 clk = ~clk;

    sublime_voice_scheduler #(.NUM_VOICES(8), .SLOT_CYCLES(4)) dut (
        .clk_i(clk), .rst_i(rst), .sample_tick_i(tick), .note_we_i(we),
        .note_voice_i(nv), .note_velocity_i(nvel), .active_voice_o(av),
        .active_voice_changed_o(ch), .active_voice_velocity_o(vel),
        .busy_o(busy), .overrun_o(ovr)
    );

    sublime_voice_scheduler #(.NUM_VOICES(5), .SLOT_CYCLES(1)) dut2 (
        .clk_i(clk), .rst_i(rst), .sample_tick_i(tick2), .note_we_i(we2),
        .note_voice_i(nv2), .note_velocity_i(nvel2), .active_voice_o(av2),
        .active_voice_changed_o(ch2), .active_voice_velocity_o(vel2),
        .busy_o(busy2), .overrun_o(ovr2)
    );

    function automatic logic exp_busy(input int t);
        return (t >= busy_from) && (t <= busy_until);
    endfunction

    function automatic logic exp_ovr(input int t);
        return (t == ovr_at);
    endfunction

    task automatic model_clear();
        q.delete();
        q2.delete();
        for (int i = 0; i < 8; i++) m_tab[i] = 0;
        for (int i = 0; i < 5; i++) m2[i] = 0;
        busy_from  = 0;
        busy_until = -1;
        ovr_at     = -1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; tick = 1'b0; we = 1'b0; nv = 3'd0; nvel = 8'd0;
        tick2 = 1'b0; we2 = 1'b0; nv2 = 3'd0; nvel2 = 8'd0;
        @(negedge clk);
        rst = 1'b0;
        model_clear();
    endtask

    task automatic idle_inputs();
        rst = 1'b0; tick = 1'b0; we = 1'b0; tick2 = 1'b0; we2 = 1'b0;
    endtask

    // Frame acceptance model: a tick is taken when idle or in the last frame cycle.
    task automatic drive_tick(input int t);
        tick = 1'b1;
        if (t >= busy_until) begin
            if (t > busy_until) busy_from = t + 1;
            busy_until = t + 32;
            for (int k = 0; k < 8; k++) q.push_back('{t + 1 + 4 * k, 7 - k, m_tab[7 - k]});
        end else begin
            ovr_at = t + 1;
        end
    endtask

    // A write at cycle t is seen by strobes whose read happens after t (strobe cycle > t+1).
    task automatic drive_write(input int t, input int v, input int val);
        we = 1'b1; nv = v[2:0]; nvel = val[7:0];
        m_tab[v] = val;
        foreach (q[i]) if (q[i].voice == v && q[i].cyc > t + 1) q[i].vel = val;
    endtask

    task automatic test_reset();
        do_reset();
        for (int t = 0; t < 4; t++) begin
            @(negedge clk);
            total++; if (av !== 3'd7)   $display("FAIL reset_voice t=%0d got %0d want 7", t, av);   else passed++;
            total++; if (ch !== 1'b0)   $display("FAIL reset_changed t=%0d got %0b want 0", t, ch); else passed++;
            total++; if (vel !== 8'h00) $display("FAIL reset_vel t=%0d got %0h want 0", t, vel);    else passed++;
            total++; if (busy !== 1'b0) $display("FAIL reset_busy t=%0d got %0b want 0", t, busy);  else passed++;
            total++; if (ovr !== 1'b0)  $display("FAIL reset_ovr t=%0d got %0b want 0", t, ovr);    else passed++;
            total++; if (av2 !== 3'd4)  $display("FAIL reset_voice2 t=%0d got %0d want 4", t, av2); else passed++;
            idle_inputs();
        end
    endtask

    task automatic test_basic_frame();
        exp_t e;
        do_reset();
        for (int t = 0; t <= 46; t++) begin
            @(negedge clk);
            if (ch === 1'b1) begin
                total++;
                if (q.size() == 0) $display("FAIL basic_extra_strobe t=%0d voice=%0d", t, av);
                else begin
                    e = q.pop_front();
                    if (e.cyc !== t || av !== e.voice[2:0] || vel !== e.vel[7:0])
                        $display("FAIL basic_strobe t=%0d got v=%0d vel=%0h want t=%0d v=%0d vel=%0h", t, av, vel, e.cyc, e.voice, e.vel);
                    else passed++;
                end
            end else if (q.size() != 0 && q[0].cyc <= t) begin
                e = q.pop_front(); total++;
                $display("FAIL basic_missing_strobe t=%0d want v=%0d", t, e.voice);
            end
            total++; if (busy !== exp_busy(t)) $display("FAIL basic_busy t=%0d got %0b want %0b", t, busy, exp_busy(t)); else passed++;
            total++; if (ovr !== exp_ovr(t))   $display("FAIL basic_ovr t=%0d got %0b want %0b", t, ovr, exp_ovr(t));    else passed++;
            idle_inputs();
            if (t < 8) drive_write(t, t, t * 16 + 1);
            if (t == 10) drive_tick(t);
        end
        total++; if (q.size() != 0) $display("FAIL basic_left_over got %0d want 0", q.size()); else passed++;
    endtask

    task automatic test_back_to_back();
        exp_t e;
        do_reset();
        for (int t = 0; t <= 78; t++) begin
            @(negedge clk);
            if (ch === 1'b1) begin
                total++;
                if (q.size() == 0) $display("FAIL b2b_extra_strobe t=%0d voice=%0d", t, av);
                else begin
                    e = q.pop_front();
                    if (e.cyc !== t || av !== e.voice[2:0] || vel !== e.vel[7:0])
                        $display("FAIL b2b_strobe t=%0d got v=%0d vel=%0h want t=%0d v=%0d vel=%0h", t, av, vel, e.cyc, e.voice, e.vel);
                    else passed++;
                end
            end else if (q.size() != 0 && q[0].cyc <= t) begin
                e = q.pop_front(); total++;
                $display("FAIL b2b_missing_strobe t=%0d want v=%0d", t, e.voice);
            end
            total++; if (busy !== exp_busy(t)) $display("FAIL b2b_busy t=%0d got %0b want %0b", t, busy, exp_busy(t)); else passed++;
            total++; if (ovr !== 1'b0)         $display("FAIL b2b_ovr t=%0d got %0b want 0", t, ovr);                   else passed++;
            idle_inputs();
            if (t < 8) drive_write(t, t, 8'hA0 + t);
            if (t == 10 || t == 42) drive_tick(t);
        end
        total++; if (q.size() != 0) $display("FAIL b2b_left_over got %0d want 0", q.size()); else passed++;
    endtask

    task automatic test_overrun();
        exp_t e;
        do_reset();
        for (int t = 0; t <= 46; t++) begin
            @(negedge clk);
            if (ch === 1'b1) begin
                total++;
                if (q.size() == 0) $display("FAIL ovr_extra_strobe t=%0d voice=%0d", t, av);
                else begin
                    e = q.pop_front();
                    if (e.cyc !== t || av !== e.voice[2:0] || vel !== e.vel[7:0])
                        $display("FAIL ovr_strobe t=%0d got v=%0d vel=%0h want t=%0d v=%0d vel=%0h", t, av, vel, e.cyc, e.voice, e.vel);
                    else passed++;
                end
            end else if (q.size() != 0 && q[0].cyc <= t) begin
                e = q.pop_front(); total++;
                $display("FAIL ovr_missing_strobe t=%0d want v=%0d", t, e.voice);
            end
            total++; if (busy !== exp_busy(t)) $display("FAIL ovr_busy t=%0d got %0b want %0b", t, busy, exp_busy(t)); else passed++;
            total++; if (ovr !== exp_ovr(t))   $display("FAIL ovr_pulse t=%0d got %0b want %0b", t, ovr, exp_ovr(t));   else passed++;
            idle_inputs();
            if (t < 8) drive_write(t, t, t * 16 + 1);
            if (t == 10 || t == 20) drive_tick(t);
        end
        total++; if (q.size() != 0) $display("FAIL ovr_left_over got %0d want 0", q.size()); else passed++;
    endtask

    task automatic test_write_collision();
        exp_t e;
        do_reset();
        for (int t = 0; t <= 78; t++) begin
            @(negedge clk);
            if (ch === 1'b1) begin
                total++;
                if (q.size() == 0) $display("FAIL coll_extra_strobe t=%0d voice=%0d", t, av);
                else begin
                    e = q.pop_front();
                    if (e.cyc !== t || av !== e.voice[2:0] || vel !== e.vel[7:0])
                        $display("FAIL coll_strobe t=%0d got v=%0d vel=%0h want t=%0d v=%0d vel=%0h", t, av, vel, e.cyc, e.voice, e.vel);
                    else passed++;
                end
            end else if (q.size() != 0 && q[0].cyc <= t) begin
                e = q.pop_front(); total++;
                $display("FAIL coll_missing_strobe t=%0d want v=%0d", t, e.voice);
            end
            if (t == 19) begin total++; if (vel !== 8'h20) $display("FAIL coll_v5_frame1 got %0h want 20", vel); else passed++; end
            if (t == 31) begin total++; if (vel !== 8'h33) $display("FAIL coll_v2_frame1 got %0h want 33", vel); else passed++; end
            if (t == 51) begin total++; if (vel !== 8'h7F) $display("FAIL coll_v5_frame2 got %0h want 7f", vel); else passed++; end
            total++; if (busy !== exp_busy(t)) $display("FAIL coll_busy t=%0d got %0b want %0b", t, busy, exp_busy(t)); else passed++;
            idle_inputs();
            if (t < 8) drive_write(t, t, (t == 5) ? 8'h20 : t * 16 + 1);
            if (t == 19) drive_write(t, 5, 8'h7F);
            if (t == 20) drive_write(t, 2, 8'h33);
            if (t == 10 || t == 42) drive_tick(t);
        end
        total++; if (q.size() != 0) $display("FAIL coll_left_over got %0d want 0", q.size()); else passed++;
    endtask

    task automatic test_midframe_reset();
        exp_t e;
        do_reset();
        for (int t = 0; t <= 66; t++) begin
            @(negedge clk);
            if (ch === 1'b1) begin
                total++;
                if (q.size() == 0) $display("FAIL mrst_extra_strobe t=%0d voice=%0d", t, av);
                else begin
                    e = q.pop_front();
                    if (e.cyc !== t || av !== e.voice[2:0] || vel !== e.vel[7:0])
                        $display("FAIL mrst_strobe t=%0d got v=%0d vel=%0h want t=%0d v=%0d vel=%0h", t, av, vel, e.cyc, e.voice, e.vel);
                    else passed++;
                end
            end else if (q.size() != 0 && q[0].cyc <= t) begin
                e = q.pop_front(); total++;
                $display("FAIL mrst_missing_strobe t=%0d want v=%0d", t, e.voice);
            end
            if (t == 26) begin
                total++; if (av !== 3'd7)   $display("FAIL mrst_voice got %0d want 7", av); else passed++;
                total++; if (vel !== 8'h00) $display("FAIL mrst_vel got %0h want 0", vel);  else passed++;
                total++; if (ch !== 1'b0)   $display("FAIL mrst_changed got %0b want 0", ch); else passed++;
            end
            total++; if (busy !== exp_busy(t)) $display("FAIL mrst_busy t=%0d got %0b want %0b", t, busy, exp_busy(t)); else passed++;
            total++; if (ovr !== 1'b0)         $display("FAIL mrst_ovr t=%0d got %0b want 0", t, ovr);                   else passed++;
            idle_inputs();
            if (t < 8) drive_write(t, t, t * 16 + 1);
            if (t == 10) drive_tick(t);
            if (t == 25) begin
                // Reset wins over a simultaneous tick and table write.
                rst = 1'b1; tick = 1'b1; we = 1'b1; nv = 3'd3; nvel = 8'h55;
                q.delete();
                for (int i = 0; i < 8; i++) m_tab[i] = 0;
                busy_until = t;
            end
            if (t == 30) drive_tick(t);
        end
        total++; if (q.size() != 0) $display("FAIL mrst_left_over got %0d want 0", q.size()); else passed++;
    endtask

    task automatic test_slot1_nv5();
        exp_t e;
        do_reset();
        for (int t = 0; t <= 20; t++) begin
            @(negedge clk);
            if (ch2 === 1'b1) begin
                total++;
                if (q2.size() == 0) $display("FAIL s1_extra_strobe t=%0d voice=%0d", t, av2);
                else begin
                    e = q2.pop_front();
                    if (e.cyc !== t || av2 !== e.voice[2:0] || vel2 !== e.vel[7:0])
                        $display("FAIL s1_strobe t=%0d got v=%0d vel=%0h want t=%0d v=%0d vel=%0h", t, av2, vel2, e.cyc, e.voice, e.vel);
                    else passed++;
                end
            end else if (q2.size() != 0 && q2[0].cyc <= t) begin
                e = q2.pop_front(); total++;
                $display("FAIL s1_missing_strobe t=%0d want v=%0d", t, e.voice);
            end
            total++; if (busy2 !== (t >= 11 && t <= 15)) $display("FAIL s1_busy t=%0d got %0b", t, busy2); else passed++;
            total++; if (ovr2 !== 1'b0) $display("FAIL s1_ovr t=%0d got %0b want 0", t, ovr2); else passed++;
            idle_inputs();
            if (t < 5) begin
                we2 = 1'b1; nv2 = t[2:0]; nvel2 = 8'h10 + t[7:0]; m2[t] = 16 + t;
            end
            if (t == 5) begin
                we2 = 1'b1; nv2 = 3'd6; nvel2 = 8'hEE;
            end
            if (t == 10) begin
                tick2 = 1'b1;
                for (int k = 0; k < 5; k++) q2.push_back('{t + 1 + k, 4 - k, m2[4 - k]});
            end
        end
        total++; if (q2.size() != 0) $display("FAIL s1_left_over got %0d want 0", q2.size()); else passed++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; tick = 1'b0; we = 1'b0; nv = 3'd0; nvel = 8'd0;
        tick2 = 1'b0; we2 = 1'b0; nv2 = 3'd0; nvel2 = 8'd0;
        model_clear();
        test_reset();
        test_basic_frame();
        test_back_to_back();
        test_overrun();
        test_write_collision();
        test_midframe_reset();
        test_slot1_nv5();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/sublime_voice_scheduler.md
Name: sublime_voice_scheduler

Overview:
- Frame sequencer that drives the voice-mixer side of the time-multiplexed voice bus.
- On each audio sample tick, it walks all voices from NUM_VOICES-1 down to 0. For each voice it issues a one-cycle voice strobe with the voice index and the current velocity from an internal per-voice velocity table.
- Voice 0 is always the final strobe of a frame; downstream mixing treats it as the frame boundary.
- The velocity table is written by the note/control logic (MIDI/bus side).

Parameters:
- NUM_VOICES, 8, number of voices per frame (>=2).
- SLOT_CYCLES, 4, clock cycles per voice slot (>=1); gives the oscillator/filter pipeline time between strobes.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- sample_tick  in  1  one-cycle pulse that starts a frame
- note_we  in  1  velocity-table write enable
- note_voice  in  $clog2(NUM_VOICES)  voice index to write
- note_velocity  in  8  velocity to store; 0 means silent
- active_voice  out  $clog2(NUM_VOICES)  index of the voice currently strobed
- active_voice_changed  out  1  one-cycle strobe per voice slot
- active_voice_velocity  out  8  velocity for active_voice, valid with the strobe
- busy  out  1  high while a frame is in progress
- overrun  out  1  one-cycle pulse when a sample_tick is dropped

Behaviour:
- Reset values:
  - active_voice = NUM_VOICES-1
  - active_voice_changed = 0, active_voice_velocity = 0, busy = 0, overrun = 0
  - all velocity table entries = 0
  - FSM = IDLE
- All outputs are registered.
- FSM states: IDLE, RUN.
  - Slot counter: 0..SLOT_CYCLES-1.
  - Voice counter: NUM_VOICES-1 down to 0.
- IDLE + sample_tick at cycle T:
  - At T+1: RUN, busy=1, slot=0, active_voice=NUM_VOICES-1, active_voice_changed=1, active_voice_velocity=table[NUM_VOICES-1].
- RUN, slot advance:
  - Slot increments every cycle.
  - active_voice_changed is high only in slot 0 of each voice.
  - When slot==SLOT_CYCLES-1 and voice!=0: next cycle decrements voice, slot=0, strobes with the new voice's velocity.
- RUN, end of frame:
  - Last frame cycle = slot==SLOT_CYCLES-1 with voice==0.
  - Next cycle: IDLE, busy=0, active_voice holds 0.
- Frame timing: strobes at T+1+k*SLOT_CYCLES for k=0..NUM_VOICES-1; busy high T+1 .. T+NUM_VOICES*SLOT_CYCLES.
- Back-to-back frames:
  - A sample_tick in the last frame cycle is accepted.
  - Next cycle restarts at voice NUM_VOICES-1 with a strobe; busy stays high with no gap.
- Dropped ticks:
  - A sample_tick in any other RUN cycle is ignored and overrun pulses high the following cycle.
  - The current frame is unaffected.
- SLOT_CYCLES=1: a strobe every cycle, voices in consecutive cycles.
- Velocity table:
  - Synchronous write, one port; read is registered into active_voice_velocity at strobe issue.
  - A write to voice v in the same cycle the strobe for v is registered yields the old value; the new value appears from the next frame.
  - A write to a voice not yet visited in the current frame takes effect in this frame.
  - note_voice >= NUM_VOICES: write ignored (non-power-of-2 NUM_VOICES).
- Reset mid-frame: next cycle all outputs are at reset values, table cleared, no further strobes.
- Reset takes priority over sample_tick and note_we in the same cycle.

Decomposition:
- Shared constants header: FSM state encodings (IDLE, RUN) and the velocity width (8), shared with the mixer and the note-control logic.
- One sub-module: sublime_voice_table, a NUM_VOICES x 8 register file.
  - Ports: clk, rst, write port, combinational read address and data.
  - rst clears all entries.
  - Out-of-range write suppression lives inside it.
- The FSM and counters stay in the top.

Test Plan (NUM_VOICES=8, SLOT_CYCLES=4 unless stated):
- Basic frame:
  - Stimulus: table[v]=v*16+1, tick at cycle 10.
  - Required: strobes at 11,15,19,...,39 with voices 7..0 and velocities 0x71,0x61,...,0x01; busy high 11..42; low at 43.
- Back-to-back:
  - Stimulus: ticks at 10 and 42.
  - Required: second frame's voice 7 strobe at 43; busy continuous 11..74; overrun never asserted.
- Overrun:
  - Stimulus: ticks at 10 and 20.
  - Required: overrun=1 at 21 only; frame timing identical to the basic frame; no extra strobes.
- Write collision:
  - Stimulus: table[5]=0x20, write 0x7F to voice 5 at cycle 19 (voice 5 strobe registered), tick at 10 and again at 42.
  - Required: frame 1 voice 5 velocity = 0x20, frame 2 = 0x7F.
  - Also: write voice 2 = 0x33 at cycle 20 → frame 1 voice 2 strobe (cycle 31) shows 0x33.
- Mid-frame reset:
  - Stimulus: tick at 10, rst at 25.
  - Required: at 26 changed=0, busy=0, active_voice=7, velocity=0; next frame shows all velocities 0.
- SLOT_CYCLES=1, NUM_VOICES=5:
  - Stimulus: tick at 10; write to note_voice=6 at cycle 5.
  - Required: strobes at 11..15 with voices 4..0; busy 11..15; the voice-6 write has no effect.
